// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline definitions: write-back source encodings,
//               default datapath/register-address widths, zero-register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Default datapath and register-address widths
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  // Architectural zero register index
  localparam int REG_ZERO = 0;

  // Write-back source select encodings
  localparam logic [1:0] WB_SEL_ALU   = 2'b00;
  localparam logic [1:0] WB_SEL_MEM   = 2'b01;
  localparam logic [1:0] WB_SEL_SHIFT = 2'b10;
  localparam logic [1:0] WB_SEL_LINK  = 2'b11;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/wb_select_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_mux
// Description : 4:1 write-back source multiplexer (ALU, memory, shifter,
//               link PC). Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_select_mux
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W
) (
  input  logic [1:0]        write_back,
  input  logic [DATA_W-1:0] ALU_output,
  input  logic [DATA_W-1:0] read_data_memory,
  input  logic [DATA_W-1:0] shift_output,
  input  logic [DATA_W-1:0] link_pc,
  output logic [DATA_W-1:0] wb_data
);

  // Pick the write-back value from the source named by write_back
  always_comb begin
    wb_data = ALU_output;
    case (write_back)
      WB_SEL_ALU:   wb_data = ALU_output;
      WB_SEL_MEM:   wb_data = read_data_memory;
      WB_SEL_SHIFT: wb_data = shift_output;
      WB_SEL_LINK:  wb_data = link_pc;
      default:      wb_data = ALU_output;
    endcase
  end

endmodule : wb_select_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Write-back stage and 2^ADDR_W x DATA_W architectural register
//               file with two asynchronous read ports, hardwired-zero R0 and
//               a wrapping 16-bit committed-write counter.
//               Optional macro WB_REGFILE_BYPASS_EN: when defined, a read of
//               the register being committed this cycle returns wb_data
//               (write-through); otherwise reads return stored contents.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        write_back,
  input  logic [DATA_W-1:0] link_pc,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] ALU_output,
  input  logic [DATA_W-1:0] shift_output,
  input  logic [DATA_W-1:0] read_data_memory,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       wb_count
);

  localparam int              C_NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [C_NUM_REGS];
  logic [15:0]       r_wb_count;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  wb_select_mux #(
    .DATA_W (DATA_W)
  ) u_wb_select_mux (
    .write_back       (write_back),
    .ALU_output       (ALU_output),
    .read_data_memory (read_data_memory),
    .shift_output     (shift_output),
    .link_pc          (link_pc),
    .wb_data          (w_wb_data)
  );

  // Writes to R0 are discarded; reset priority is applied in the register process
  assign w_commit = RegWrite && (write_address != C_ZERO_ADDR);

  // Register storage: clear on reset, otherwise commit the write-back value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[write_address] <= w_wb_data;
    end
  end

  // Committed-write counter; wraps silently at 0xFFFF
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_count <= '0;
    end else if (w_commit) begin
      r_wb_count <= r_wb_count + 16'd1;
    end
  end

  // Read ports: stored contents, optional write-through, R0 forced to zero
  always_comb begin
    w_rd_a = r_regs[rd_addr_a];
    w_rd_b = r_regs[rd_addr_b];
`ifdef WB_REGFILE_BYPASS_EN
    // A write being lost to reset must not be forwarded either
    if (w_commit && !reset && (rd_addr_a == write_address)) begin
      w_rd_a = w_wb_data;
    end
    if (w_commit && !reset && (rd_addr_b == write_address)) begin
      w_rd_b = w_wb_data;
    end
`endif
    if (rd_addr_a == C_ZERO_ADDR) begin
      w_rd_a = '0;
    end
    if (rd_addr_b == C_ZERO_ADDR) begin
      w_rd_b = '0;
    end
  end

  assign rd_data_a = w_rd_a;
  assign rd_data_b = w_rd_b;
  assign wb_data   = w_wb_data;
  assign wb_count  = r_wb_count;

endmodule : wb_regfile
`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value from ALU, shifter, data memory or link PC, and commits it to a 16 x 16-bit register file. Two combinational read ports serve the decode stage. A committed-write counter supports debug and performance checks.

## Interface
- DATA_W, 16, register and datapath width
- ADDR_W, 4, register address width (2^ADDR_W registers)

- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- write_back  in  2  write-back source select: 00 ALU, 01 memory, 10 shifter, 11 link PC
- link_pc  in  DATA_W  return address for link instructions
- write_address  in  ADDR_W  destination register
- ALU_output  in  DATA_W  ALU result
- shift_output  in  DATA_W  shifter result
- read_data_memory  in  DATA_W  data memory load value
- RegWrite  in  1  commit enable
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data
- rd_data_b  out  DATA_W  read port B data
- wb_data  out  DATA_W  selected write-back value, combinational, for EX forwarding
- wb_count  out  16  number of committed writes

## Operation
- wb_data = source picked by write_back; pure combinational, valid every cycle regardless of RegWrite.
- Commit condition: RegWrite=1, write_address!=0, reset=0. On the rising edge, regs[write_address] <= wb_data and wb_count increments by 1.
- R0 is hardwired zero: writes to R0 are dropped, do not count, and reads of R0 return 0x0000 on both ports in all modes.
- Read ports are asynchronous: rd_data_x = regs[rd_addr_x], with bypass per Configuration.
- Both read ports may address the same register; both return the same value.
- wb_count wraps 0xFFFF -> 0x0000 with no flag.
- Reset: all registers R1..R15 <= 0x0000, wb_count <= 0 on the rising edge with reset=1. wb_data remains combinational and is not reset. Consequently rd_data_a/b read 0x0000 after the reset edge.
- Reset overrides a commit in the same cycle: the write is lost and the count does not increment.

## Timing
- wb_data: 0-cycle latency from inputs.
- Write: value visible in regs one edge after the cycle with the commit condition.
- Read: 0-cycle combinational from rd_addr and register state.
- Same-cycle read/write of one register: see Configuration.
- No handshakes. The block never stalls and accepts one write per cycle.

## Configuration
- WB_REGFILE_BYPASS_EN defined: if the commit condition holds and rd_addr_x == write_address, rd_data_x = wb_data in the same cycle (write-through). This closes the WB->ID hazard. Reset=1 disables the bypass.
- Not defined: rd_data_x always returns stored contents. The old value is returned in the write cycle, and the new value from the next cycle. The hazard unit must stall one extra cycle.

## Structure
- Shared package pipeline_pkg:
  - write-back select encodings WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_SHIFT=2'b10, WB_SEL_LINK=2'b11
  - DATA_W, ADDR_W defaults
  - REG_ZERO=0
- One sub-module, wb_select_mux: the 4:1 write-back source mux producing wb_data. The storage, bypass and counter stay in wb_regfile.

## Test plan
- Reset held 2 cycles, then read all addresses -> every rd_data = 0x0000, wb_count = 0.
- write_back=00, ALU_output=0x1234, write_address=3, RegWrite=1 for one cycle; then rd_addr_a=3 -> rd_data_a=0x1234, wb_count=1. Repeat with sel 01/10/11 into R4/R5/R6 using 0xBEEF/0x0F0F/0x0042 -> each value reads back correctly, wb_count=4.
- Write 0xFFFF to R0 with RegWrite=1 -> rd_data_a/b for address 0 = 0x0000, wb_count unchanged.
- R7=0x1111 stored, write 0x2222 to R7 with rd_addr_b=7 in the same cycle:
  - with bypass: rd_data_b=0x2222 in that cycle
  - without bypass: 0x1111, then 0x2222 next cycle
- RegWrite=1 to R9 with 0xAAAA and reset=1 in the same cycle -> R9 = 0x0000 afterwards, wb_count = 0. Also 65536 commits from reset -> wb_count wraps to 0x0000.
